// File: rtl/inc_share_arbiter.sv
// Round-robin arbiter time-sharing one 4-bit half-adder-chain incrementer among four counters.
// One clock from req to ack + updated count; no queueing, so a requester holds req level until it sees ack.
module inc_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         clr,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ*WIDTH-1:0]   count,
  output logic [NREQ-1:0]         ovf,
  output logic                    busy
);

  localparam int PTRW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [PTRW-1:0]      ptr;
  logic [NREQ-1:0]      elig;
  logic                 gnt_vld;
  logic [PTRW-1:0]      gnt_idx;
  logic [PTRW-1:0]      probe;
  logic [NREQ-1:0]      gnt_oh;
  logic [WIDTH-1:0]     inc_a;
  logic [WIDTH-1:0]     inc_sum;
  logic                 inc_cout;
  logic [NREQ*WIDTH-1:0] count_nxt;
  logic [NREQ-1:0]      ovf_nxt;

  // A clear always wins over an increment for the same requester.
  assign elig = req & ~clr;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    probe   = '0;
    for (int k = 0; k < NREQ; k++) begin
      probe = ptr + PTRW'(k);
      if (!gnt_vld && elig[probe]) begin
        gnt_vld = 1'b1;
        gnt_idx = probe;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == PTRW'(i));
    end
  end

  always_comb begin
    inc_a = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) inc_a = count[i*WIDTH +: WIDTH];
    end
  end

  inc_ha_chain #(.WIDTH(WIDTH)) u_inc (
    .a    (inc_a),
    .sum  (inc_sum),
    .cout (inc_cout)
  );

  // Granted lanes take the incrementer result; cleared lanes zero; the rest hold.
  always_comb begin
    count_nxt = count;
    ovf_nxt   = ovf;
    for (int i = 0; i < NREQ; i++) begin
      if (clr[i]) begin
        count_nxt[i*WIDTH +: WIDTH] = '0;
        ovf_nxt[i]                  = 1'b0;
      end else if (gnt_oh[i]) begin
        count_nxt[i*WIDTH +: WIDTH] = inc_sum;
        ovf_nxt[i]                  = ovf[i] | inc_cout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      ack   <= '0;
      count <= '0;
      ovf   <= '0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
      ack   <= gnt_oh;
      if (gnt_vld) begin
        state <= GRANT;
        ptr   <= gnt_idx + PTRW'(1);
      end else begin
        state <= IDLE;
      end
    end
  end

  assign busy = (state == GRANT);

endmodule

// Ripple chain of half adders computing a + 1 with carry-out.
module inc_ha_chain #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i] = a[i] ^ c[i];
    assign c[i+1] = a[i] & c[i];
  end

  assign cout = c[WIDTH];

endmodule

// File: tb/tb_inc_share_arbiter.sv
// Directed bench for inc_share_arbiter: hand-computed expectations, inputs driven and outputs sampled on negedge.
module tb_inc_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  clr;
  logic [3:0]  ack;
  logic [15:0] count;
  logic [3:0]  ovf;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  inc_share_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .clr   (clr),
    .ack   (ack),
    .count (count),
    .ovf   (ovf),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req = 4'b0000;
    clr = 4'b0000;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] exp_ack;
    rst_n = 1'b0;
    req   = 4'b0000;
    clr   = 4'b0000;
    #2;
    check("rst_ack",   ack,   0);
    check("rst_count", count, 0);
    check("rst_ovf",   ovf,   0);
    check("rst_busy",  busy,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lone requester is granted every cycle.
    req = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("t1_ack",   ack,          32'h1);
      check("t1_cnt0",  count[3:0],   k);
      check("t1_busy",  busy,         32'h1);
      check("t1_other", count[15:4],  32'h0);
    end

    // Full contention rotates from ptr=0.
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_ack = 4'b0001 << (k % 4);
      check("t2_ack", ack, exp_ack);
    end
    check("t2_count", count, 32'h2222);

    // Wrap of count2 sets a sticky ovf.
    req = 4'b0000;
    clr = 4'b0100;
    step();
    clr = 4'b0000;
    check("t3_clr_count", count, 32'h2022);
    check("t3_clr_ovf",   ovf,   32'h0);
    req = 4'b0100;
    repeat (14) step();
    check("t3_cnt2_e",  count[11:8], 32'hE);
    check("t3_ovf_e",   ovf[2],      32'h0);
    step();
    check("t3_cnt2_f",  count[11:8], 32'hF);
    check("t3_ovf_f",   ovf[2],      32'h0);
    step();
    check("t3_cnt2_0",  count[11:8], 32'h0);
    check("t3_ovf_wrap", ovf[2],     32'h1);
    check("t3_ack_wrap", ack,        32'h4);
    step();
    check("t3_cnt2_1",  count[11:8], 32'h1);
    check("t3_ovf_stk", ovf,         32'h4);
    check("t3_count",   count,       32'h2122);

    // Clear beats request; ptr advances past the actual grant.
    apply_reset();
    req = 4'b0001;
    repeat (16) step();
    check("t4_pre_cnt0", count[3:0], 32'h0);
    check("t4_pre_ovf",  ovf,        32'h1);
    req = 4'b1000;
    step();
    check("t4_pre_ack",   ack,   32'h8);
    check("t4_pre_count", count, 32'h1000);
    req = 4'b0011;
    clr = 4'b0001;
    step();
    clr = 4'b0000;
    check("t4_ack",   ack,   32'h2);
    check("t4_count", count, 32'h1010);
    check("t4_ovf",   ovf,   32'h0);
    req = 4'b1111;
    step();
    check("t4_ptr_ack", ack,   32'h4);
    check("t4_ptr_cnt", count, 32'h1110);

    // Asynchronous reset mid-cycle during full contention.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_ack",   ack,   0);
    check("t5_count", count, 0);
    check("t5_ovf",   ovf,   0);
    check("t5_busy",  busy,  0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t5_first_ack", ack,   32'h1);
    check("t5_first_cnt", count, 32'h0001);
    step();
    check("t5_next_ack",  ack,   32'h2);
    check("t5_next_cnt",  count, 32'h0011);

    // Idle: outputs drop, state holds, ptr unchanged.
    req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t6_ack",   ack,   0);
      check("t6_busy",  busy,  0);
      check("t6_count", count, 32'h0011);
      check("t6_ovf",   ovf,   0);
    end
    req = 4'b1111;
    step();
    check("t6_resume_ack", ack,  32'h4);
    check("t6_resume_bsy", busy, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inc_share_arbiter.md
Name: inc_share_arbiter

Overview:
- Round-robin arbiter that time-shares one 4-bit half-adder-chain incrementer among four requesters.
- Each requester owns a 4-bit count register; the arbiter grants at most one requester per clock.
- The granted requester's register is routed through the shared incrementer and written back.
- Sits between the requester logic and the single incrementer instance, so only one incrementer is needed per cluster.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 for this revision.
- WIDTH, 4, count width; fixed at 4 to match the shared incrementer.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  level request per requester; bit i means "increment count i".
- clr  input  4  synchronous clear per requester.
- ack  output  4  one-hot, one-cycle pulse; bit i means count i was incremented at this edge.
- count  output  16  count i on bits [4i+3:4i], registered.
- ovf  output  4  sticky wrap flag per requester; set by the incrementer Cout.
- busy  output  1  registered; high in the cycle after any grant (equals OR of ack).

Behaviour:
- Reset:
  - rst_n low asynchronously forces count=0, ovf=0, ack=0, busy=0 and round-robin pointer ptr=0.
  - Reset asserted mid-operation discards any in-flight grant; no ack is issued for it.
- Arbitration, combinational within each cycle:
  - The eligible set is req & ~clr.
  - Search starts at index ptr and proceeds ptr, ptr+1, ... modulo 4.
  - The first eligible index g is granted.
  - No eligible bit means no grant, ptr holds, and ack=0 next cycle.
- Datapath:
  - The shared incrementer input is count[g].
  - Result sum = count[g]+1 (4 bits) with carry-out Cout.
  - At the edge, count[g] <= sum.
  - ovf[g] <= ovf[g] | Cout.
  - ack <= one-hot(g), busy <= 1, ptr <= (g+1) mod 4.
- Latency: one clock from req sampled high to ack pulse and updated count, both visible in the same cycle.
- Requests:
  - req is level-sensitive, with no internal queue.
  - A requester holding req high is incremented once per grant; it is re-granted only after the others have had their turn, giving at most 1 grant per 4 cycles under full contention.
  - A requester wanting exactly one increment drops req in the cycle ack is seen.
  - Single-requester case: a lone active requester is granted every cycle.
- Wrap-around: 4'hF + 1 gives 4'h0 with Cout=1, so ovf[i] sets and stays set until clr[i] or reset.
- Clear:
  - clr[i] sets count[i] <= 0 and ovf[i] <= 0 at the edge.
  - clr has priority over increment: a requester with clr high is not eligible that cycle and receives no ack.
  - Other requesters are arbitrated normally.
  - Simultaneous clr on several bits clears all of them.
- Non-granted counts and ovf bits hold their values.
- The arbiter has exactly two states, IDLE (no grant this cycle) and GRANT (grant issued). busy reflects GRANT registered.

Test Plan:
1. Reset then req=4'b0001 for 3 cycles:
   - ack[0] pulses each cycle.
   - count0 steps 1, 2, 3.
   - busy=1 throughout; other counts stay 0.
2. req=4'b1111 held for 8 cycles from ptr=0:
   - ack sequence is 0001, 0010, 0100, 1000, repeating.
   - Every count ends at 2.
3. count2 preloaded to 4'hE via 14 grants, then 2 more grants:
   - count2 goes to 4'hF, then to 4'h0.
   - ovf[2]=1 after the wrap and stays 1 across further increments.
4. req=4'b0011 and clr=4'b0001 in the same cycle with ptr=0:
   - ack=4'b0010, count1 increments, count0=0.
   - ovf[0] is cleared; ptr ends at 2.
5. rst_n dropped asynchronously mid-cycle while req=4'b1111:
   - All outputs go to 0 immediately.
   - After release with req still high, the first ack is 4'b0001.
6. req=4'b0000 for 5 cycles after activity:
   - ack=0 and busy=0 from the second idle cycle on.
   - Counts and ovf hold; ptr is unchanged, checked by the next grant order.
